phase_dagger_stream: RTL and testbench

Streaming inverse phase gate (S†, matrix [1 0; 0 −i]) that applies the conjugate of the phase-gate rotation to a full state vector. Amplitudes arrive in index order over a valid/ready stream. The block multiplies every amplitude whose target-qubit index bit is 1 by −i and passes the rest unchanged. It sits between the state-vector memory reader and writer in the gate datapath and is used to uncompute S rotations.

---
 rtl/gate_pkg.sv | 31 +++
 rtl/stream_reg.sv | 33 +++
 rtl/phase_dagger_stream.sv | 113 +++++++++++
 tb/tb_phase_dagger_stream.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared gate-datapath types: fixed-point amplitude, stream FSM states, saturating negate.
package gate_pkg;

  localparam int FIXED_WIDTH = 16;

  typedef struct packed {
    logic signed [FIXED_WIDTH-1:0] re;
    logic signed [FIXED_WIDTH-1:0] im;
  } amp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic signed [FIXED_WIDTH-1:0] AMP_MIN = {1'b1, {(FIXED_WIDTH-1){1'b0}}};
  localparam logic signed [FIXED_WIDTH-1:0] AMP_MAX = {1'b0, {(FIXED_WIDTH-1){1'b1}}};

  // The most negative value has no positive twin, so it clamps to the maximum.
  function automatic logic signed [FIXED_WIDTH-1:0] sat_neg(
    input logic signed [FIXED_WIDTH-1:0] x
  );
    if (x == AMP_MIN) begin
      return AMP_MAX;
    end
    return -x;
  endfunction

endpackage

// File: rtl/stream_reg.sv
// One-stage valid/ready register carrying an amplitude and its last flag.
module stream_reg
  import gate_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  amp_t in_data,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output amp_t out_data,
  output logic out_last
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/phase_dagger_stream.sv
// Streaming S-dagger gate: amplitudes whose target-qubit index bit is set are multiplied by -i.
module phase_dagger_stream
  import gate_pkg::*;
#(
  parameter int NUM_QUBITS  = 4,
  // Must equal gate_pkg::FIXED_WIDTH, since amp_t is sized from the package.
  parameter int FIXED_WIDTH = gate_pkg::FIXED_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(NUM_QUBITS)-1:0]   target,
  output logic                            busy,
  output logic                            done,
  output logic                            len_err,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [FIXED_WIDTH-1:0]   in_real,
  input  logic signed [FIXED_WIDTH-1:0]   in_imag,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [FIXED_WIDTH-1:0]   out_real,
  output logic signed [FIXED_WIDTH-1:0]   out_imag,
  output logic                            out_last
);

  localparam logic [NUM_QUBITS:0] LAST_IDX = (NUM_QUBITS+1)'((1 << NUM_QUBITS) - 1);

  state_t                          state;
  logic [NUM_QUBITS:0]             idx;
  logic [$clog2(NUM_QUBITS)-1:0]   tgt;
  logic                            reg_ready;
  logic                            accept;
  logic                            at_last;
  amp_t                            xf_amp;
  amp_t                            out_amp;

  assign in_ready = (state == ST_RUN) && reg_ready;
  assign accept   = in_valid && in_ready;
  assign at_last  = (idx == LAST_IDX);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  always_comb begin
    xf_amp.re = in_real;
    xf_amp.im = in_imag;
    if (idx[tgt]) begin
      xf_amp.re = in_imag;
      xf_amp.im = sat_neg(in_real);
    end
  end

  stream_reg u_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_ready  (reg_ready),
    .in_data   (xf_amp),
    .in_last   (at_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_amp),
    .out_last  (out_last)
  );

  assign out_real = out_amp.re;
  assign out_imag = out_amp.im;

  // Frame length is fixed by the index count; in_last only feeds the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      tgt     <= '0;
      len_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            tgt     <= target;
            idx     <= '0;
            len_err <= 1'b0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            idx <= idx + 1'b1;
            if (in_last != at_last) begin
              len_err <= 1'b1;
            end
            if (at_last) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_dagger_stream.sv
// Directed bench for phase_dagger_stream with a per-frame expected-output model and literal pins.
module tb_phase_dagger_stream;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [0:0]         target;
  logic               busy, done, len_err;
  logic               in_valid, in_ready, in_last;
  logic signed [15:0] in_real, in_imag;
  logic               out_valid, out_ready, out_last;
  logic signed [15:0] out_real, out_imag;

  int checks = 0;
  int errors = 0;

  int vre[4];
  int vim[4];
  int exp_re[$];
  int exp_im[$];
  int got_re[4];
  int got_im[4];
  int out_beat = 0;
  int done_cnt = 0;
  bit bp_mode  = 1'b0;

  bit prev_stall = 1'b0;
  int hold_re, hold_im;
  bit hold_last;

  phase_dagger_stream #(.NUM_QUBITS(2), .FIXED_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target),
    .busy(busy), .done(done), .len_err(len_err),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? ~out_ready : 1'b1;
    end
  end

  // Output checker: every handshake against the model, and held data while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall) begin
        checks++;
        if (!out_valid || int'(out_real) != hold_re || int'(out_imag) != hold_im || out_last != hold_last) begin
          errors++;
          $display("FAIL hold: got v=%0b (%0d,%0d) last=%0b, need v=1 (%0d,%0d) last=%0b",
                   out_valid, out_real, out_imag, out_last, hold_re, hold_im, hold_last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_re.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got (%0d,%0d), need no output", out_real, out_imag);
        end else begin
          int er, ei;
          bit el;
          er = exp_re.pop_front();
          ei = exp_im.pop_front();
          el = (out_beat == 3);
          if (int'(out_real) != er || int'(out_imag) != ei || out_last != el) begin
            errors++;
            $display("FAIL beat%0d: got (%0d,%0d) last=%0b, need (%0d,%0d) last=%0b",
                     out_beat, out_real, out_imag, out_last, er, ei, el);
          end
          if (out_beat < 4) begin
            got_re[out_beat] = int'(out_real);
            got_im[out_beat] = int'(out_imag);
          end
          out_beat++;
        end
      end
      prev_stall = out_valid && !out_ready;
      hold_re    = int'(out_real);
      hold_im    = int'(out_imag);
      hold_last  = out_last;
    end
  end

  task automatic check(input string name, input int got, input int need);
    checks++;
    if (got != need) begin
      errors++;
      $display("FAIL %s: got %0d, need %0d", name, got, need);
    end
  endtask

  task automatic check_lit(input int k, input int re, input int im);
    checks++;
    if (got_re[k] != re || got_im[k] != im) begin
      errors++;
      $display("FAIL lit%0d: got (%0d,%0d), need (%0d,%0d)", k, got_re[k], got_im[k], re, im);
    end
  endtask

  task automatic set_frame(input int r0, input int i0, input int r1, input int i1,
                           input int r2, input int i2, input int r3, input int i3);
    vre[0] = r0; vim[0] = i0; vre[1] = r1; vim[1] = i1;
    vre[2] = r2; vim[2] = i2; vre[3] = r3; vim[3] = i3;
  endtask

  // S-dagger on index k: multiply by -i when bit tgt of k is set, clamp the negation at +32767.
  task automatic build_model(input int tgt);
    exp_re.delete();
    exp_im.delete();
    for (int k = 0; k < 4; k++) begin
      if (((k >> tgt) & 1) == 1) begin
        int n;
        n = -vre[k];
        if (n > 32767) n = 32767;
        exp_re.push_back(vim[k]);
        exp_im.push_back(n);
      end else begin
        exp_re.push_back(vre[k]);
        exp_im.push_back(vim[k]);
      end
    end
  endtask

  task automatic drive_frame(input int tgt, input int lastpos, input bit bp,
                             input int abort_after, input bit start_in_done, input bit exp_err);
    int k;
    int guard;
    bit hs;
    build_model(tgt);
    out_beat = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    bp_mode = bp;
    start   = 1'b1;
    target  = 1'(tgt);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("started_busy", int'(busy), 1);
    check("start_clears_len_err", int'(len_err), 0);
    @(posedge clk); #1;
    k = 0;
    guard = 0;
    while (k < 4 && guard < 100) begin
      if (abort_after >= 0 && k == abort_after) break;
      in_valid = 1'b1;
      in_real  = 16'(vre[k]);
      in_imag  = 16'(vim[k]);
      in_last  = (k == lastpos);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL input_timeout: got %0d beats accepted, need 4", k);
    end
    if (abort_after >= 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_in_ready", int'(in_ready), 0);
      exp_re.delete();
      exp_im.delete();
      bp_mode = 1'b0;
      return;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done pulse, need one");
    end
    if (start_in_done && done_cnt > 0) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("start_in_done_ignored_busy", int'(busy), 0);
    end
    repeat (3) @(negedge clk);
    #1;
    bp_mode = 1'b0;
    check("done_pulses", done_cnt, 1);
    check("out_count", out_beat, 4);
    check("model_drained", exp_re.size(), 0);
    check("len_err", int'(len_err), int'(exp_err));
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target = '0;
    in_valid = 1'b0; in_last = 1'b0; in_real = '0; in_imag = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_len_err", int'(len_err), 0);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_real", int'(out_real), 0);
    check("reset_out_imag", int'(out_imag), 0);
    check("reset_out_last", int'(out_last), 0);

    set_frame(100, 5, 200, 6, 300, 7, 400, 8);
    drive_frame(0, 3, 1'b0, -1, 1'b0, 1'b0);
    check_lit(0, 100, 5); check_lit(1, 6, -200); check_lit(2, 300, 7); check_lit(3, 8, -400);

    drive_frame(1, 3, 1'b0, -1, 1'b0, 1'b0);
    check_lit(0, 100, 5); check_lit(1, 200, 6); check_lit(2, 7, -300); check_lit(3, 8, -400);

    drive_frame(0, 3, 1'b1, -1, 1'b0, 1'b0);
    check_lit(0, 100, 5); check_lit(1, 6, -200); check_lit(2, 300, 7); check_lit(3, 8, -400);

    set_frame(1, 2, -32768, 0, 3, 4, -32768, -32768);
    drive_frame(0, 3, 1'b0, -1, 1'b0, 1'b0);
    check_lit(1, 0, 32767); check_lit(3, -32768, 32767);

    set_frame(100, 5, 200, 6, 300, 7, 400, 8);
    drive_frame(0, 1, 1'b0, -1, 1'b1, 1'b1);
    drive_frame(1, 3, 1'b1, -1, 1'b0, 1'b0);
    drive_frame(1, -1, 1'b0, -1, 1'b0, 1'b1);

    drive_frame(0, 3, 1'b0, 2, 1'b0, 1'b0);
    drive_frame(0, 3, 1'b0, -1, 1'b0, 1'b0);
    check_lit(0, 100, 5); check_lit(1, 6, -200); check_lit(2, 300, 7); check_lit(3, 8, -400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, need finish");
    $fatal(1);
  end

endmodule
